// File: rtl/poly_mult_loader.sv
// -----------------------------------------------------------------------------
// poly_mult_loader
//
// Host-facing load/readback front end for the sparse polynomial multiplier.
// Two dual-port RAMs hold the operands:
//   - position RAM     : WEIGHT   x POS_WIDTH, host keys 0 .. WEIGHT-1
//   - random-bits RAM  : RB_DEPTH x RB_WIDTH,  host keys WEIGHT .. WEIGHT+RB_DEPTH-1
// Port A of each RAM belongs to the host command FSM, port B is a read-only
// port for the multiplier core.
//
// Host side uses a ready/valid handshake:
//   load_i, op_i (0 write / 1 read), key_i, data_i  -> command, taken when
//                                                     load_i && ready_o
//   ready_o                                         -> FSM idle
//   valid_o, data_o, err_o                          -> one-cycle response
//   lock_i                                          -> core running; host
//                                                     writes are refused
// Core side:
//   core_pos_addr_i -> core_pos_o  (MEM_LATENCY cycles)
//   core_rb_addr_i  -> core_rb_o   (MEM_LATENCY cycles)
//
// Response latency measured from the accept edge: error 1, write 2,
// read MEM_LATENCY+1 cycles.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// poly_mult_loader_dpram
//
// Simple dual-port RAM: port A read/write, port B read-only, both with a
// registered read path of LATENCY (1 or 2) cycles.
//   we_a, addr_a, din_a -> write port A
//   q_a                 -> port A read data, LATENCY cycles after addr_a
//   addr_b, q_b         -> port B read, LATENCY cycles after addr_b
// -----------------------------------------------------------------------------
module poly_mult_loader_dpram #(
   parameter int DEPTH   = 66,
   parameter int WIDTH   = 16,
   parameter int LATENCY = 1,
   parameter int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_a,
   input  logic [AW-1:0]    addr_a,
   input  logic [WIDTH-1:0] din_a,
   output logic [WIDTH-1:0] q_a,
   input  logic [AW-1:0]    addr_b,
   output logic [WIDTH-1:0] q_b
);

   // NOTE: the storage array and its read registers have no reset; a reset
   // term would stop the array mapping onto block RAM, and nothing relies on
   // the contents being cleared.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   // NOTE: every clocked assignment uses <= so all registers sample the
   // pre-edge values; blocking assignments here would make the result depend
   // on statement order.
   always_ff @(posedge clk) begin
      if (we_a) begin
         mem[addr_a] <= din_a;
      end
      rd_a <= mem[addr_a];
      rd_b <= mem[addr_b];
   end

   generate
      if (LATENCY >= 2) begin : g_out_reg
         // Extra output register for timing closure on the RAM read path.
         always_ff @(posedge clk) begin
            q_a <= rd_a;
            q_b <= rd_b;
         end
      end else begin : g_no_out_reg
         assign q_a = rd_a;
         assign q_b = rd_b;
      end
   endgenerate

endmodule

// -----------------------------------------------------------------------------
// poly_mult_loader (top)
// -----------------------------------------------------------------------------
module poly_mult_loader #(
   parameter int WEIGHT      = 66,
   parameter int POS_WIDTH   = 16,
   parameter int RB_DEPTH    = 553,
   parameter int RB_WIDTH    = 32,
   parameter int KEY_WIDTH   = 10,   // 2**KEY_WIDTH >= WEIGHT+RB_DEPTH
   parameter int DATA_WIDTH  = 128,  // >= max(POS_WIDTH, RB_WIDTH)
   parameter int MEM_LATENCY = 1     // 1 or 2
) (
   input  logic                          clk,
   input  logic                          rst,
   // host command / response
   input  logic                          load_i,
   input  logic                          op_i,
   input  logic [KEY_WIDTH-1:0]          key_i,
   input  logic [DATA_WIDTH-1:0]         data_i,
   output logic                          ready_o,
   output logic                          valid_o,
   output logic [DATA_WIDTH-1:0]         data_o,
   output logic                          err_o,
   // core interface
   input  logic                          lock_i,
   input  logic [$clog2(WEIGHT)-1:0]     core_pos_addr_i,
   output logic [POS_WIDTH-1:0]          core_pos_o,
   input  logic [$clog2(RB_DEPTH)-1:0]   core_rb_addr_i,
   output logic [RB_WIDTH-1:0]           core_rb_o
);

   localparam int POS_AW = $clog2(WEIGHT);
   localparam int RB_AW  = $clog2(RB_DEPTH);
   localparam int WD_W   = (POS_WIDTH > RB_WIDTH) ? POS_WIDTH : RB_WIDTH;

   // Key region bounds, one bit wider than the key so that a key space filled
   // exactly to 2**KEY_WIDTH still compares correctly.
   localparam logic [KEY_WIDTH:0]   POS_END = (KEY_WIDTH+1)'(WEIGHT);
   localparam logic [KEY_WIDTH:0]   RB_END  = (KEY_WIDTH+1)'(WEIGHT + RB_DEPTH);
   localparam logic [KEY_WIDTH-1:0] RB_BASE = KEY_WIDTH'(WEIGHT);

   localparam logic       OP_WRITE = 1'b0;
   localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      RD_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   // Command captured at accept
   logic                  cmd_is_rb_q;
   logic [POS_AW-1:0]     pos_addr_q;
   logic [RB_AW-1:0]      rb_addr_q;
   logic [WD_W-1:0]       wdata_q;
   logic [1:0]            lat_cnt_q;

   // Response registers
   logic [DATA_WIDTH-1:0] data_q;
   logic                  err_q;

   // Key decode of the live host key
   logic [KEY_WIDTH:0]    key_ext;
   logic                  key_is_pos;
   logic                  key_valid;
   logic [KEY_WIDTH-1:0]  key_rb_off;

   // FSM strobes
   logic                  accept;
   logic                  cmd_err;
   logic                  capture;

   // RAM port A
   logic [POS_AW-1:0]     pos_addr_a;
   logic [RB_AW-1:0]      rb_addr_a;
   logic                  pos_we_a;
   logic                  rb_we_a;
   logic [POS_WIDTH-1:0]  pos_q_a;
   logic [RB_WIDTH-1:0]   rb_q_a;

   // ---------------------------------------------------------------------------
   // Key decode
   // ---------------------------------------------------------------------------
   assign key_ext    = {1'b0, key_i};
   assign key_is_pos = (key_ext < POS_END);
   assign key_valid  = (key_ext < RB_END);
   assign key_rb_off = key_i - RB_BASE;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal driven here gets a default before the case statement,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      cmd_err = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_i) begin
               accept = 1'b1;
               if (!key_valid || (op_i == OP_WRITE && lock_i)) begin
                  cmd_err = 1'b1;
                  state_d = RESP;
               end else if (op_i == OP_WRITE) begin
                  state_d = WRITE;
               end else begin
                  state_d = RD_WAIT;
               end
            end
         end
         WRITE: begin
            state_d = RESP;
         end
         RD_WAIT: begin
            // The read was launched at the accept edge from the live key, so
            // q is valid after MEM_LATENCY edges; capture on the last one.
            if (lat_cnt_q == LAT_LAST) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Command capture and response datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_is_rb_q <= 1'b0;
         pos_addr_q  <= '0;
         rb_addr_q   <= '0;
         wdata_q     <= '0;
         lat_cnt_q   <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         if (accept) begin
            cmd_is_rb_q <= !key_is_pos;
            pos_addr_q  <= key_i[POS_AW-1:0];
            rb_addr_q   <= key_rb_off[RB_AW-1:0];
            wdata_q     <= data_i[WD_W-1:0];
            lat_cnt_q   <= '0;
         end else if (state_q == RD_WAIT) begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
         end

         if (accept && cmd_err) begin
            data_q <= '1;
            err_q  <= 1'b1;
         end else if (state_q == WRITE) begin
            data_q <= cmd_is_rb_q ? DATA_WIDTH'(wdata_q[RB_WIDTH-1:0])
                                  : DATA_WIDTH'(wdata_q[POS_WIDTH-1:0]);
            err_q  <= 1'b0;
         end else if (capture) begin
            data_q <= cmd_is_rb_q ? DATA_WIDTH'(rb_q_a) : DATA_WIDTH'(pos_q_a);
            err_q  <= 1'b0;
         end
      end
   end

   // Host data bits above the widest region are never stored.
   generate
      if (DATA_WIDTH > WD_W) begin : g_unused_data
         logic unused_data_hi;
         assign unused_data_hi = ^data_i[DATA_WIDTH-1:WD_W];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // RAM port A control
   // ---------------------------------------------------------------------------
   // In IDLE the address follows the live key so that a read is launched on
   // the accept edge itself; afterwards the captured address is held.
   assign pos_addr_a = (state_q == IDLE) ? key_i[POS_AW-1:0]      : pos_addr_q;
   assign rb_addr_a  = (state_q == IDLE) ? key_rb_off[RB_AW-1:0]  : rb_addr_q;

   // Decoded from the state register, so an asynchronous reset drops the
   // write enable immediately.
   assign pos_we_a = (state_q == WRITE) && !cmd_is_rb_q;
   assign rb_we_a  = (state_q == WRITE) &&  cmd_is_rb_q;

   poly_mult_loader_dpram #(
      .DEPTH   (WEIGHT),
      .WIDTH   (POS_WIDTH),
      .LATENCY (MEM_LATENCY),
      .AW      (POS_AW)
   ) u_pos_ram (
      .clk    (clk),
      .we_a   (pos_we_a),
      .addr_a (pos_addr_a),
      .din_a  (wdata_q[POS_WIDTH-1:0]),
      .q_a    (pos_q_a),
      .addr_b (core_pos_addr_i),
      .q_b    (core_pos_o)
   );

   poly_mult_loader_dpram #(
      .DEPTH   (RB_DEPTH),
      .WIDTH   (RB_WIDTH),
      .LATENCY (MEM_LATENCY),
      .AW      (RB_AW)
   ) u_rb_ram (
      .clk    (clk),
      .we_a   (rb_we_a),
      .addr_a (rb_addr_a),
      .din_a  (wdata_q[RB_WIDTH-1:0]),
      .q_a    (rb_q_a),
      .addr_b (core_rb_addr_i),
      .q_b    (core_rb_o)
   );

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign ready_o = (state_q == IDLE);
   assign valid_o = (state_q == RESP);
   assign err_o   = (state_q == RESP) && err_q;
   assign data_o  = data_q;

endmodule

// File: tb/tb_poly_mult_loader.sv
// -----------------------------------------------------------------------------
// tb_poly_mult_loader
//
// Directed bench for poly_mult_loader with default parameters. Each host
// command is driven through do_cmd(), which checks ready handshake, response
// latency, err_o and data_o against hand-computed values.
// -----------------------------------------------------------------------------
module tb_poly_mult_loader;

   localparam int WEIGHT      = 66;
   localparam int POS_WIDTH   = 16;
   localparam int RB_DEPTH    = 553;
   localparam int RB_WIDTH    = 32;
   localparam int KEY_WIDTH   = 10;
   localparam int DATA_WIDTH  = 128;
   localparam int MEM_LATENCY = 1;

   localparam logic OP_WR = 1'b0;
   localparam logic OP_RD = 1'b1;

   localparam int LAT_WR  = 2;
   localparam int LAT_RD  = MEM_LATENCY + 1;
   localparam int LAT_ERR = 1;

   localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};

   logic                          clk;
   logic                          rst;
   logic                          load_i;
   logic                          op_i;
   logic [KEY_WIDTH-1:0]          key_i;
   logic [DATA_WIDTH-1:0]         data_i;
   logic                          ready_o;
   logic                          valid_o;
   logic [DATA_WIDTH-1:0]         data_o;
   logic                          err_o;
   logic                          lock_i;
   logic [$clog2(WEIGHT)-1:0]     core_pos_addr_i;
   logic [POS_WIDTH-1:0]          core_pos_o;
   logic [$clog2(RB_DEPTH)-1:0]   core_rb_addr_i;
   logic [RB_WIDTH-1:0]           core_rb_o;

   int n_vec = 0;
   int n_err = 0;

   poly_mult_loader #(
      .WEIGHT      (WEIGHT),
      .POS_WIDTH   (POS_WIDTH),
      .RB_DEPTH    (RB_DEPTH),
      .RB_WIDTH    (RB_WIDTH),
      .KEY_WIDTH   (KEY_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .MEM_LATENCY (MEM_LATENCY)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .load_i          (load_i),
      .op_i            (op_i),
      .key_i           (key_i),
      .data_i          (data_i),
      .ready_o         (ready_o),
      .valid_o         (valid_o),
      .data_o          (data_o),
      .err_o           (err_o),
      .lock_i          (lock_i),
      .core_pos_addr_i (core_pos_addr_i),
      .core_pos_o      (core_pos_o),
      .core_rb_addr_i  (core_rb_addr_i),
      .core_rb_o       (core_rb_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                        input logic [DATA_WIDTH-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one host command and check its full response.
   task automatic do_cmd(input string tag, input logic op, input int key,
                         input logic [DATA_WIDTH-1:0] data, input int exp_lat,
                         input logic exp_err, input logic [DATA_WIDTH-1:0] exp_data);
      int n;
      n = 0;
      while (!ready_o && n < 10) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, DATA_WIDTH'(ready_o), DATA_WIDTH'(1'b1));
      load_i = 1'b1;
      op_i   = op;
      key_i  = KEY_WIDTH'(key);
      data_i = data;
      tick();
      // Scramble the inputs: the command must have been sampled at accept.
      load_i = 1'b0;
      op_i   = ~op;
      key_i  = '1;
      data_i = ONES;
      check({tag, "_busy"}, DATA_WIDTH'(ready_o), DATA_WIDTH'(1'b0));
      n = 1;
      while (!valid_o && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_lat"},  DATA_WIDTH'(n), DATA_WIDTH'(exp_lat));
      check({tag, "_err"},  DATA_WIDTH'(err_o), DATA_WIDTH'(exp_err));
      check({tag, "_data"}, data_o, exp_data);
      tick();
      check({tag, "_vdrop"}, DATA_WIDTH'({valid_o, err_o}), DATA_WIDTH'(2'b00));
   endtask

   initial begin
      rst             = 1'b1;
      load_i          = 1'b0;
      op_i            = 1'b0;
      key_i           = '0;
      data_i          = '0;
      lock_i          = 1'b0;
      core_pos_addr_i = '0;
      core_rb_addr_i  = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_ready", DATA_WIDTH'(ready_o), DATA_WIDTH'(1'b1));
      check("rst_valid", DATA_WIDTH'(valid_o), DATA_WIDTH'(1'b0));
      check("rst_err",   DATA_WIDTH'(err_o),   DATA_WIDTH'(1'b0));
      check("rst_data",  data_o,               '0);

      // Position region write/readback, including truncation to 16 bits
      do_cmd("wr_k5",  OP_WR, 5, 128'h1234, LAT_WR, 1'b0, 128'h1234);
      do_cmd("rd_k5",  OP_RD, 5, 128'h0,    LAT_RD, 1'b0, 128'h1234);
      check("hold_data", data_o, 128'h1234);
      do_cmd("wr_k0",  OP_WR, 0, 128'hFFFF_0009_8765, LAT_WR, 1'b0, 128'h8765);
      do_cmd("wr_k65", OP_WR, 65, 128'hBEEF, LAT_WR, 1'b0, 128'hBEEF);
      do_cmd("rd_k0",  OP_RD, 0,  128'h0, LAT_RD, 1'b0, 128'h8765);
      do_cmd("rd_k65", OP_RD, 65, 128'h0, LAT_RD, 1'b0, 128'hBEEF);

      // Random-bits region, truncation to 32 bits, core port B
      do_cmd("wr_k66", OP_WR, 66, 128'hDEADBEEF_CAFEF00D, LAT_WR, 1'b0, 128'hCAFEF00D);
      core_rb_addr_i  = 10'd0;
      core_pos_addr_i = 7'd5;
      tick();
      check("core_rb0",  DATA_WIDTH'(core_rb_o),  128'hCAFEF00D);
      check("core_pos5", DATA_WIDTH'(core_pos_o), 128'h1234);
      do_cmd("wr_k618", OP_WR, 618, 128'h11223344, LAT_WR, 1'b0, 128'h11223344);
      core_rb_addr_i = 10'd552;
      tick();
      check("core_rb552", DATA_WIDTH'(core_rb_o), 128'h11223344);
      do_cmd("rd_k618", OP_RD, 618, 128'h0, LAT_RD, 1'b0, 128'h11223344);

      // Zero is a legal write value and must not behave as a read
      do_cmd("wr_k70a", OP_WR, 70, 128'h55AA, LAT_WR, 1'b0, 128'h55AA);
      do_cmd("wr_k70z", OP_WR, 70, 128'h0,    LAT_WR, 1'b0, 128'h0);
      do_cmd("rd_k70",  OP_RD, 70, 128'h0,    LAT_RD, 1'b0, 128'h0);

      // Out-of-range keys
      do_cmd("rd_k619",  OP_RD, 619,  128'h0,    LAT_ERR, 1'b1, ONES);
      check("err_hold", data_o, ONES);
      do_cmd("wr_k1023", OP_WR, 1023, 128'h7777, LAT_ERR, 1'b1, ONES);

      // Lock interlock: writes refused, reads allowed
      do_cmd("wr_k3",    OP_WR, 3, 128'h3333, LAT_WR, 1'b0, 128'h3333);
      lock_i = 1'b1;
      do_cmd("wr_k3_lk", OP_WR, 3, 128'h7777, LAT_ERR, 1'b1, ONES);
      do_cmd("rd_k3_lk", OP_RD, 3, 128'h0,    LAT_RD,  1'b0, 128'h3333);
      lock_i = 1'b0;

      // A write already accepted completes even if lock rises afterwards
      load_i = 1'b1; op_i = OP_WR; key_i = 10'd4; data_i = 128'h4444;
      tick();
      load_i = 1'b0;
      lock_i = 1'b1;
      tick();
      check("lklate_valid", DATA_WIDTH'({valid_o, err_o}), DATA_WIDTH'(2'b10));
      tick();
      do_cmd("rd_k4", OP_RD, 4, 128'h0, LAT_RD, 1'b0, 128'h4444);
      lock_i = 1'b0;

      // load_i while busy is ignored
      load_i = 1'b1; op_i = OP_WR; key_i = 10'd10; data_i = 128'h1111;
      tick();
      data_i = 128'h2222;
      tick();
      load_i = 1'b0;
      check("busy_ld_data", data_o, 128'h1111);
      tick();
      do_cmd("rd_k10", OP_RD, 10, 128'h0, LAT_RD, 1'b0, 128'h1111);

      // Reset asserted during RD_WAIT
      load_i = 1'b1; op_i = OP_RD; key_i = 10'd5;
      tick();
      load_i = 1'b0;
      check("rdw_busy", DATA_WIDTH'(ready_o), DATA_WIDTH'(1'b0));
      rst = 1'b1;
      #1;
      check("rdw_rst_ready", DATA_WIDTH'(ready_o), DATA_WIDTH'(1'b1));
      check("rdw_rst_valid", DATA_WIDTH'(valid_o), DATA_WIDTH'(1'b0));
      check("rdw_rst_data",  data_o, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      do_cmd("post_wr_k600", OP_WR, 600, 128'h0BADF00D, LAT_WR, 1'b0, 128'h0BADF00D);
      do_cmd("post_rd_k600", OP_RD, 600, 128'h0,        LAT_RD, 1'b0, 128'h0BADF00D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
